// File: rtl/riscv_perf_monitor.sv
// Observational performance monitor for the pipelined RISC-V core: saturating event counters,
// end-of-run idle detection and shadow direct-mapped I/D caches. PERF_DCACHE_MODEL_EN enables the D-side model.

module perf_shadow_cache #(
  parameter int ADDR_W    = 32,
  parameter int SETS_LOG2 = 6,
  parameter int LINE_LOG2 = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              access,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  localparam int SETS  = 1 << SETS_LOG2;
  localparam int TAG_W = ADDR_W - LINE_LOG2 - SETS_LOG2;

  logic [SETS-1:0]      valid;
  logic [TAG_W-1:0]     tags [SETS];
  logic [SETS_LOG2-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic                 unused_offset;

  assign idx           = addr[LINE_LOG2+SETS_LOG2-1:LINE_LOG2];
  assign tag           = addr[ADDR_W-1:LINE_LOG2+SETS_LOG2];
  assign unused_offset = ^addr[LINE_LOG2-1:0];
  assign hit           = valid[idx] && (tags[idx] == tag);

  always_ff @(posedge clock or posedge reset)
    if (reset)       valid <= '0;
    else if (clear)  valid <= '0;
    else if (access) valid[idx] <= 1'b1;

  // Tag storage has no reset; the valid bits alone qualify it.
  always_ff @(posedge clock)
    if (access && !hit) tags[idx] <= tag;
endmodule

module riscv_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int ADDR_W     = 32,
  parameter int SETS_LOG2  = 6,
  parameter int LINE_LOG2  = 4,
  parameter int IDLE_LIMIT = 5,
  parameter bit PRED_TAKEN = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              ex_reg_write,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic              ex_pc_src,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  branch_ok_cnt,
  output logic [CNT_W-1:0]  ic_acc_cnt,
  output logic [CNT_W-1:0]  ic_hit_cnt,
  output logic [CNT_W-1:0]  dc_acc_cnt,
  output logic [CNT_W-1:0]  dc_hit_cnt,
  output logic [1:0]        state,
  output logic              done
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b11} state_t;

  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
  localparam int C_CYC = 0, C_INS = 1, C_BR = 2, C_OK = 3, C_ICA = 4, C_ICH = 5;
`ifdef PERF_DCACHE_MODEL_EN
  localparam int NUM_CNT = 8;
`else
  localparam int NUM_CNT = 6;
`endif

  state_t                          st, st_nxt;
  logic [IDLE_W-1:0]               idle_run;
  logic [NUM_CNT-1:0][CNT_W-1:0]   cnt;
  logic [NUM_CNT-1:0]              inc;
  logic                            active, count_en, last_idle, ic_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign active    = ex_reg_write | ex_mem_write | ex_branch | ex_jump;
  assign count_en  = (st == S_RUN) && enable && !clear;
  assign last_idle = count_en && !active && (idle_run == IDLE_W'(IDLE_LIMIT - 1));

  perf_shadow_cache #(.ADDR_W(ADDR_W), .SETS_LOG2(SETS_LOG2), .LINE_LOG2(LINE_LOG2)) u_ic (
    .clock(clock), .reset(reset), .clear(clear), .access(count_en), .addr(if_pc), .hit(ic_hit)
  );

`ifdef PERF_DCACHE_MODEL_EN
  logic dc_acc, dc_hit;
  assign dc_acc = count_en && (mem_write || mem_read);
  perf_shadow_cache #(.ADDR_W(ADDR_W), .SETS_LOG2(SETS_LOG2), .LINE_LOG2(LINE_LOG2)) u_dc (
    .clock(clock), .reset(reset), .clear(clear), .access(dc_acc), .addr(mem_addr), .hit(dc_hit)
  );
  assign dc_acc_cnt = cnt[6];
  assign dc_hit_cnt = cnt[7];
`else
  logic unused_mem;
  assign unused_mem = ^{mem_write, mem_read, mem_addr};
  assign dc_acc_cnt = '0;
  assign dc_hit_cnt = '0;
`endif

  always_comb begin
    inc        = '0;
    inc[C_CYC] = 1'b1;
    inc[C_INS] = active;
    inc[C_BR]  = ex_branch;
    inc[C_OK]  = ex_branch && (ex_pc_src == PRED_TAKEN);
    inc[C_ICA] = 1'b1;
    inc[C_ICH] = ic_hit;
`ifdef PERF_DCACHE_MODEL_EN
    inc[6]     = mem_write || mem_read;
    inc[7]     = (mem_write || mem_read) && dc_hit;
`endif
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (enable) st_nxt = S_RUN;
      S_RUN:   if (last_idle) st_nxt = S_DONE;
      default: st_nxt = st;
    endcase
    if (clear) st_nxt = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st       <= S_IDLE;
      idle_run <= '0;
    end else begin
      st <= st_nxt;
      if (clear)         idle_run <= '0;
      else if (count_en) idle_run <= active ? '0 : idle_run + IDLE_W'(1);
    end

  // On the final idle cycle the trailing idle cycles are backed out of cycle_cnt.
  always_ff @(posedge clock or posedge reset)
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (count_en) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= sat_inc(cnt[i], inc[i]);
      if (last_idle) cnt[C_CYC] <= cnt[C_CYC] - CNT_W'(IDLE_LIMIT - 1);
    end

  assign cycle_cnt     = cnt[C_CYC];
  assign instr_cnt     = cnt[C_INS];
  assign branch_cnt    = cnt[C_BR];
  assign branch_ok_cnt = cnt[C_OK];
  assign ic_acc_cnt    = cnt[C_ICA];
  assign ic_hit_cnt    = cnt[C_ICH];
  assign state         = st;
  assign done          = (st == S_DONE);
endmodule

// File: tb/tb_riscv_perf_monitor.sv
// Randomized + directed bench for riscv_perf_monitor: two instances (32-bit/not-taken, 4-bit/taken)
// checked every cycle against a spec-level model.
module tb_riscv_perf_monitor;
  logic clock = 1'b0;
  logic reset, enable, clear, ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_pc_src;
  logic mem_write, mem_read;
  logic [31:0] if_pc, mem_addr;
  logic [7:0][31:0] oa;
  logic [7:0][3:0]  ob;
  logic [1:0] st_a, st_b;
  logic dn_a, dn_b;

  always #5 clock = ~clock;

  riscv_perf_monitor u_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_pc_src(ex_pc_src), .if_pc(if_pc), .mem_write(mem_write),
    .mem_read(mem_read), .mem_addr(mem_addr),
    .cycle_cnt(oa[0]), .instr_cnt(oa[1]), .branch_cnt(oa[2]), .branch_ok_cnt(oa[3]),
    .ic_acc_cnt(oa[4]), .ic_hit_cnt(oa[5]), .dc_acc_cnt(oa[6]), .dc_hit_cnt(oa[7]),
    .state(st_a), .done(dn_a)
  );

  riscv_perf_monitor #(.CNT_W(4), .PRED_TAKEN(1'b1)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_pc_src(ex_pc_src), .if_pc(if_pc), .mem_write(mem_write),
    .mem_read(mem_read), .mem_addr(mem_addr),
    .cycle_cnt(ob[0]), .instr_cnt(ob[1]), .branch_cnt(ob[2]), .branch_ok_cnt(ob[3]),
    .ic_acc_cnt(ob[4]), .ic_hit_cnt(ob[5]), .dc_acc_cnt(ob[6]), .dc_hit_cnt(ob[7]),
    .state(st_b), .done(dn_b)
  );

  // Reference model: run phase + per-configuration counts + line maps keyed by set index.
  longint mc [2][8];
  int     mst, midl;
  longint icm [int];
  longint dcm [int];
  int     total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input longint exp);
    total++;
    if (got !== 64'(exp)) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) mc[k][i] = 0;
    mst = 0; midl = 0;
    icm.delete(); dcm.delete();
  endtask

  task automatic minc(input int k, input int i, input bit c);
    longint mx = (k == 0) ? 64'hFFFF_FFFF : 15;
    if (c && mc[k][i] < mx) mc[k][i]++;
  endtask

  task automatic model_step();
    bit act, ih, dh, da;
    int idx;
    longint tg, old;
    if (clear) begin model_reset(); return; end
    if (mst == 0) begin if (enable) mst = 1; return; end
    if (mst != 1 || !enable) return;
    act = ex_reg_write | ex_mem_write | ex_branch | ex_jump;
    idx = int'((if_pc >> 4) & 63); tg = longint'(if_pc >> 10);
    ih = 0;
    if (icm.exists(idx)) ih = (icm[idx] == tg);
    icm[idx] = tg;
    da = 0; dh = 0;
`ifdef PERF_DCACHE_MODEL_EN
    da = mem_write | mem_read;
    if (da) begin
      idx = int'((mem_addr >> 4) & 63); tg = longint'(mem_addr >> 10);
      if (dcm.exists(idx)) dh = (dcm[idx] == tg);
      dcm[idx] = tg;
    end
`endif
    midl = act ? 0 : midl + 1;
    for (int k = 0; k < 2; k++) begin
      old = mc[k][0];
      minc(k, 0, 1);
      minc(k, 1, act);
      minc(k, 2, ex_branch);
      minc(k, 3, ex_branch && (ex_pc_src == (k == 1)));
      minc(k, 4, 1);
      minc(k, 5, ih);
      minc(k, 6, da);
      minc(k, 7, da && dh);
      if (midl == 5) mc[k][0] = old - 4;
    end
    if (midl == 5) mst = 3;
  endtask

  task automatic cmp_all(input string ph);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_a_cnt%0d", ph, i), 64'(oa[i]), mc[0][i]);
      chk($sformatf("%s_b_cnt%0d", ph, i), 64'(ob[i]), mc[1][i]);
    end
    chk({ph, "_a_state"}, 64'(st_a), mst);
    chk({ph, "_b_state"}, 64'(st_b), mst);
    chk({ph, "_a_done"}, 64'(dn_a), longint'(mst == 3));
    chk({ph, "_b_done"}, 64'(dn_b), longint'(mst == 3));
  endtask

  task automatic step(input string ph);
    @(posedge clock);
    model_step();
    #1;
    cmp_all(ph);
  endtask

  task automatic quiet();
    ex_reg_write = 0; ex_mem_write = 0; ex_branch = 0; ex_jump = 0; ex_pc_src = 0;
    mem_write = 0; mem_read = 0;
  endtask

  logic [31:0] pcl [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h400, 32'h0};
  logic [3:0]  pcs = 4'b0010;

  initial begin
    reset = 1; enable = 0; clear = 0; if_pc = 0; mem_addr = 0; quiet();
    repeat (2) @(posedge clock);
    #1; reset = 0; model_reset();
    cmp_all("rst");

    // 10 active cycles then idle until the run ends
    enable = 1; step("t2");
    ex_reg_write = 1; repeat (10) step("t2");
    ex_reg_write = 0; repeat (5) step("t2");
    chk("t2_done", 64'(dn_a), 1);
    chk("t2_state", 64'(st_a), 3);
    chk("t2_cycles", 64'(oa[0]), 10);
    chk("t2_instr", 64'(oa[1]), 10);
    chk("t2_cycles_w4", 64'(ob[0]), 10);
    ex_reg_write = 1; repeat (2) step("t2hold");
    chk("t2_hold_cycles", 64'(oa[0]), 10);

    clear = 1; step("clr"); clear = 0; quiet();
    chk("clr_state", 64'(st_a), 0);

    // branch prediction against both static predictions
    step("t3");
    ex_branch = 1;
    for (int i = 0; i < 4; i++) begin ex_pc_src = pcs[i]; step("t3"); end
    quiet(); enable = 0; step("t3");
    chk("t3_branches", 64'(oa[2]), 4);
    chk("t3_ok_nt", 64'(oa[3]), 3);
    chk("t3_ok_taken", 64'(ob[3]), 1);

    clear = 1; step("clr"); clear = 0; enable = 1; step("t4");
    ex_reg_write = 1;
    for (int i = 0; i < 6; i++) begin if_pc = pcl[i]; step("t4"); end
    quiet(); enable = 0; step("t4");
    chk("t4_ic_acc", 64'(oa[4]), 6);
    chk("t4_ic_hit", 64'(oa[5]), 3);

    clear = 1; step("clr"); clear = 0; enable = 1; step("t5");
    ex_reg_write = 1; mem_addr = 32'h100;
    mem_read = 1; step("t5"); step("t5");
    mem_read = 0; mem_write = 1; step("t5");
    quiet(); enable = 0; step("t5");
`ifdef PERF_DCACHE_MODEL_EN
    chk("t5_dc_acc", 64'(oa[6]), 3);
    chk("t5_dc_hit", 64'(oa[7]), 2);
`else
    chk("t5_dc_acc", 64'(oa[6]), 0);
    chk("t5_dc_hit", 64'(oa[7]), 0);
`endif

    // saturation on the narrow instance, then async reset mid-run
    clear = 1; step("clr"); clear = 0; enable = 1; step("t6");
    ex_reg_write = 1; repeat (20) step("t6");
    chk("t6_instr_w4", 64'(ob[1]), 15);
    chk("t6_instr_w32", 64'(oa[1]), 20);
    reset = 1;
    @(posedge clock); #1;
    model_reset();
    cmp_all("t1");
    chk("t1_instr", 64'(oa[1]), 0);
    chk("t1_state", 64'(st_a), 0);
    reset = 0;

    // clear while enabled mid-run
    step("t6b"); repeat (3) step("t6b");
    clear = 1; step("t6b"); clear = 0;
    chk("t6_clr_state", 64'(st_a), 0);
    chk("t6_clr_cycles", 64'(oa[0]), 0);

    for (int n = 0; n < 800; n++) begin
      enable       = ($urandom % 8) != 0;
      clear        = ($urandom % 40) == 0;
      ex_reg_write = ($urandom % 6) == 0;
      ex_mem_write = ($urandom % 6) == 0;
      ex_branch    = ($urandom % 6) == 0;
      ex_jump      = ($urandom % 6) == 0;
      ex_pc_src    = $urandom % 2;
      mem_read     = ($urandom % 3) == 0;
      mem_write    = ($urandom % 4) == 0;
      if_pc    = (($urandom % 8) == 0) ? $urandom :
                 ((($urandom % 3) << 10) | (($urandom % 4) << 4) | ($urandom % 16));
      mem_addr = (($urandom % 8) == 0) ? $urandom :
                 ((($urandom % 3) << 10) | (($urandom % 4) << 4) | ($urandom % 16));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
